// File: rtl/ultrasonic_ranger_if.sv
// Signal bundle between the HC-SR04 ranger and the logic that consumes its readings.
//   echo        sensor echo line into the ranger (asynchronous to clk)
//   trig        sensor trigger pulse out of the ranger
//   dist_cm     last measured distance, centimetres (511 = timeout / saturated)
//   dist_valid  one-cycle strobe when dist_cm/timeout change
//   timeout     the reported sample had no echo or an overlong echo
//   sens_ult    debounced presence level
//   sens_pulse  one-cycle strobe on each rising edge of sens_ult
// master: the ranger itself. slave: the sensor/consumer side (and the testbench).
interface ultrasonic_ranger_if;
  logic       echo;
  logic       trig;
  logic [8:0] dist_cm;
  logic       dist_valid;
  logic       timeout;
  logic       sens_ult;
  logic       sens_pulse;

  modport master (
    input  echo,
    output trig, dist_cm, dist_valid, timeout, sens_ult, sens_pulse
  );

  modport slave (
    output echo,
    input  trig, dist_cm, dist_valid, timeout, sens_ult, sens_pulse
  );
endinterface

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ultrasonic ranger.
// Fires a trigger pulse every PERIOD_MS, times the echo pulse in microseconds,
// converts it to centimetres and reports one sample per trigger period. The
// samples are filtered into a debounced presence level (sens_ult) that feeds
// the pet FSM's "diversion" input; dist_cm is meant for debug / 7-seg display.
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active low
//   bus   ultrasonic_ranger_if.master (echo in; trig, dist_cm, dist_valid,
//         timeout, sens_ult, sens_pulse out)
module ultrasonic_ranger #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned TRIG_US         = 10,
  parameter int unsigned PERIOD_MS       = 60,
  parameter int unsigned ECHO_TIMEOUT_US = 30000,
  parameter int unsigned US_PER_CM       = 58,
  parameter int unsigned NEAR_CM         = 15,
  parameter int unsigned CONFIRM         = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  ultrasonic_ranger_if.master  bus
);

  localparam int unsigned DIV       = CLK_HZ / 1_000_000;
  localparam int unsigned PERIOD_US = PERIOD_MS * 1000;

  localparam int PRE_W = $clog2(DIV + 1);
  localparam int TRG_W = $clog2(TRIG_US + 1);
  localparam int PER_W = $clog2(PERIOD_US + 1);
  localparam int WID_W = $clog2(ECHO_TIMEOUT_US + 1);
  localparam int SUB_W = $clog2(US_PER_CM + 1);

  localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(DIV - 1);
  localparam logic [TRG_W-1:0] TRIG_LAST    = TRG_W'(TRIG_US - 1);
  localparam logic [PER_W-1:0] PERIOD_LAST  = PER_W'(PERIOD_US - 1);
  localparam logic [WID_W-1:0] TO_LAST      = WID_W'(ECHO_TIMEOUT_US - 1);
  localparam logic [SUB_W-1:0] SUB_LAST     = SUB_W'(US_PER_CM - 1);
  localparam logic [8:0]       CM_MAX       = 9'd511;
  localparam logic [8:0]       NEAR_LIM     = 9'(NEAR_CM);
  localparam logic [3:0]       CONFIRM_LAST = 4'(CONFIRM - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    HOLDOFF
  } state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------- time base
  logic [PRE_W-1:0] pre_cnt_reg;
  logic             us_tick;

  assign us_tick = (pre_cnt_reg == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_reg <= '0;
    end else if (us_tick) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
    end
  end

  // ------------------------------------------------------------- echo input
  // Two flops of synchronisation, a third to detect edges on echo_s.
  logic echo_meta_reg, echo_s_reg, echo_d_reg;
  logic echo_rise, echo_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_meta_reg <= 1'b0;
      echo_s_reg    <= 1'b0;
      echo_d_reg    <= 1'b0;
    end else begin
      echo_meta_reg <= bus.echo;
      echo_s_reg    <= echo_meta_reg;
      echo_d_reg    <= echo_s_reg;
    end
  end

  assign echo_rise = echo_s_reg & ~echo_d_reg;
  assign echo_fall = ~echo_s_reg & echo_d_reg;

  // -------------------------------------------------------------- counters
  logic [TRG_W-1:0] trig_cnt_reg;
  logic [PER_W-1:0] period_cnt_reg;
  logic [WID_W-1:0] wait_cnt_reg;   // echo wait time in WAIT_ECHO, echo width in MEASURE
  logic [SUB_W-1:0] us_sub_reg;
  logic [8:0]       cm_reg;

  logic       trig_last, wait_last, period_done, sub_wrap;
  logic [8:0] cm_now;

  assign trig_last   = us_tick && (trig_cnt_reg == TRIG_LAST);
  assign wait_last   = us_tick && (wait_cnt_reg == TO_LAST);
  assign period_done = (period_cnt_reg == PERIOD_LAST);
  assign sub_wrap    = us_tick && (us_sub_reg == SUB_LAST);
  // Centimetre count including the current tick, so the microsecond on which
  // the fall is seen is still part of the reported width.
  assign cm_now      = (sub_wrap && (cm_reg != CM_MAX)) ? cm_reg + 9'd1 : cm_reg;

  // ------------------------------------------------------------------- FSM
  logic enter_trig, enter_wait, enter_meas, report, report_to;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    enter_trig = 1'b0;
    enter_wait = 1'b0;
    enter_meas = 1'b0;
    report     = 1'b0;
    report_to  = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = TRIG;
        enter_trig = 1'b1;
      end
      TRIG: begin
        if (trig_last) begin
          state_next = WAIT_ECHO;
          enter_wait = 1'b1;
        end
      end
      WAIT_ECHO: begin
        // An echo already high on entry never produces a rise here, so it
        // ends as a timeout sample.
        if (echo_rise) begin
          state_next = MEASURE;
          enter_meas = 1'b1;
        end else if (wait_last) begin
          state_next = HOLDOFF;
          report     = 1'b1;
          report_to  = 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          state_next = HOLDOFF;
          report     = 1'b1;
        end else if (wait_last) begin
          state_next = HOLDOFF;
          report     = 1'b1;
          report_to  = 1'b1;
        end
      end
      HOLDOFF: begin
        // Never re-trigger while the sensor is still echoing; the period
        // stretches instead.
        if (period_done && !echo_s_reg) begin
          state_next = TRIG;
          enter_trig = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_cnt_reg   <= '0;
      period_cnt_reg <= '0;
      wait_cnt_reg   <= '0;
      us_sub_reg     <= '0;
      cm_reg         <= '0;
    end else begin
      if (enter_trig) begin
        period_cnt_reg <= '0;
      end else if (us_tick && !period_done) begin
        period_cnt_reg <= period_cnt_reg + PER_W'(1);
      end

      if (enter_trig) begin
        trig_cnt_reg <= '0;
      end else if ((state_reg == TRIG) && us_tick) begin
        trig_cnt_reg <= trig_cnt_reg + TRG_W'(1);
      end

      if (enter_wait || enter_meas) begin
        wait_cnt_reg <= '0;
      end else if (((state_reg == WAIT_ECHO) || (state_reg == MEASURE)) && us_tick) begin
        wait_cnt_reg <= wait_cnt_reg + WID_W'(1);
      end

      if (enter_meas) begin
        us_sub_reg <= '0;
        cm_reg     <= '0;
      end else if ((state_reg == MEASURE) && us_tick) begin
        us_sub_reg <= sub_wrap ? '0 : us_sub_reg + SUB_W'(1);
        cm_reg     <= cm_now;
      end
    end
  end

  // ------------------------------------------------- outputs and presence filter
  logic       trig_reg, dist_valid_reg, timeout_reg, sens_ult_reg, sens_pulse_reg;
  logic [8:0] dist_cm_reg;
  logic [3:0] run_cnt_reg;
  logic       sample_near;

  // The filter acts on the sample being reported, so sens_ult changes in the
  // same cycle as the dist_valid that caused it.
  assign sample_near = !report_to && (cm_now < NEAR_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_reg       <= 1'b0;
      dist_valid_reg <= 1'b0;
      dist_cm_reg    <= '0;
      timeout_reg    <= 1'b0;
      sens_ult_reg   <= 1'b0;
      sens_pulse_reg <= 1'b0;
      run_cnt_reg    <= '0;
    end else begin
      trig_reg       <= (state_next == TRIG);
      dist_valid_reg <= report;
      sens_pulse_reg <= 1'b0;
      if (report) begin
        dist_cm_reg <= report_to ? CM_MAX : cm_now;
        timeout_reg <= report_to;
        if (sample_near != sens_ult_reg) begin
          if (run_cnt_reg == CONFIRM_LAST) begin
            sens_ult_reg   <= ~sens_ult_reg;
            sens_pulse_reg <= ~sens_ult_reg;
            run_cnt_reg    <= '0;
          end else begin
            run_cnt_reg <= run_cnt_reg + 4'd1;
          end
        end else begin
          run_cnt_reg <= '0;
        end
      end
    end
  end

  assign bus.trig       = trig_reg;
  assign bus.dist_cm    = dist_cm_reg;
  assign bus.dist_valid = dist_valid_reg;
  assign bus.timeout    = timeout_reg;
  assign bus.sens_ult   = sens_ult_reg;
  assign bus.sens_pulse = sens_pulse_reg;

endmodule
